and_stim_checker: RTL

AND_STIM_CHECKER -- requirements
Module: and_stim_checker

---
 rtl/and_stim_checker.sv | 107 ++++++++++
 1 files changed

// File: rtl/and_stim_checker.sv
// Stimulus generator and checker for a two-input AND target: walks the four
// (a,b) vectors, holds each for HOLD_CYCLES clocks, samples c and counts mismatches.
module and_stim_checker #(
  parameter int HOLD_CYCLES = 10,
  parameter int NUM_PASSES  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_SAMPLE,
    S_DONE
  } state_t;

  // DRIVE occupies HOLD_CYCLES-1 cycles: counter runs HOLD_CYCLES-2 down to 0.
  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 2);
  localparam logic [3:0] LAST_PASS   = 4'(NUM_PASSES - 1);

  state_t     state;
  logic [7:0] hold_cnt;
  logic [3:0] pass_cnt;
  logic [7:0] err_next;
  logic [1:0] vec_next;

  assign busy     = (state == S_DRIVE) || (state == S_SAMPLE);
  assign vec_next = vec_idx + 2'd1;

  always_comb begin
    err_next = err_count;
    if ((c != (a & b)) && (err_count != 8'hFF)) begin
      err_next = err_count + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      a         <= 1'b0;
      b         <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_idx   <= '0;
      hold_cnt  <= '0;
      pass_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_DRIVE;
            vec_idx   <= '0;
            pass_cnt  <= '0;
            err_count <= '0;
            pass      <= 1'b0;
            hold_cnt  <= HOLD_RELOAD;
            a         <= 1'b0;
            b         <= 1'b0;
          end
        end
        S_DRIVE: begin
          if (hold_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end
        S_SAMPLE: begin
          err_count <= err_next;
          hold_cnt  <= HOLD_RELOAD;
          if (vec_idx != 2'd3) begin
            state   <= S_DRIVE;
            vec_idx <= vec_next;
            a       <= vec_next[0];
            b       <= vec_next[1];
          end else if (pass_cnt != LAST_PASS) begin
            state    <= S_DRIVE;
            vec_idx  <= '0;
            pass_cnt <= pass_cnt + 4'd1;
            a        <= 1'b0;
            b        <= 1'b0;
          end else begin
            state <= S_DONE;
            a     <= 1'b0;
            b     <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
